frogger_move_input: RTL and testbench



---
 rtl/frogger_move_input.sv | 189 ++++++++++++++++++
 tb/tb_frogger_move_input.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frogger_move_input.sv
// Button conditioner for the Frogger movement controller: sync, debounce, arbitrate, pulse.
// Define MOVE_REPEAT_EN to build hold-to-repeat; otherwise one move per debounced press.
module frogger_move_input #(
   parameter int unsigned c_DEBOUNCE_LIMIT = 250000,
   parameter int unsigned c_REPEAT_DELAY   = 12500000,
   parameter int unsigned c_REPEAT_PERIOD  = 5000000,
   parameter int unsigned c_CNT_W          = 24
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Up_Mvt,
   input  logic       i_Down_Mvt,
   input  logic       i_Left_Mvt,
   input  logic       i_Right_Mvt,
   input  logic       i_Game_Start,
   input  logic       i_Game_Active,
   output logic       o_Move_Valid,
   output logic [1:0] o_Move_Dir,
   output logic       o_Start_Pulse,
   output logic [3:0] o_Btn_State
);

   localparam longint unsigned CntCap = 64'd1 << c_CNT_W;
   localparam logic [c_CNT_W-1:0] DbMax = c_CNT_W'(c_DEBOUNCE_LIMIT - 1);

   if (c_DEBOUNCE_LIMIT > CntCap || c_REPEAT_DELAY > CntCap || c_REPEAT_PERIOD > CntCap)
   begin : g_cnt_w_check
      $error("c_CNT_W too narrow for the configured limits");
   end

   // Bit order: {start, right, left, down, up}
   logic [4:0] raw;
   logic [4:0] sync1_q, sync2_q;
   logic [4:0] level;
   logic [4:0] prev_q;
   logic [4:0] rise;
   logic [3:0] dir_rise;

   assign raw = {i_Game_Start, i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt};

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= level;
      end
   end

   for (genvar g = 0; g < 5; g++) begin : g_db
      logic [c_CNT_W-1:0] cnt_q;
      logic               lvl_q;

      always_ff @(posedge i_Clk) begin
         if (i_Reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else if (sync2_q[g] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DbMax) begin
            cnt_q <= '0;
            lvl_q <= ~lvl_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign level[g] = lvl_q;
   end

   assign rise     = level & ~prev_q;
   assign dir_rise = rise[3:0];

   // Fixed priority: up > down > left > right
   logic [1:0] win_dir;
   always_comb begin
      if (dir_rise[0])      win_dir = 2'd0;
      else if (dir_rise[1]) win_dir = 2'd1;
      else if (dir_rise[2]) win_dir = 2'd2;
      else                  win_dir = 2'd3;
   end

`ifdef MOVE_REPEAT_EN
   typedef enum logic [1:0] {StIdle, StHeldDelay, StRepeat} state_e;

   localparam logic [c_CNT_W-1:0] DelayMax  = c_CNT_W'(c_REPEAT_DELAY - 1);
   localparam logic [c_CNT_W-1:0] PeriodMax = c_CNT_W'(c_REPEAT_PERIOD - 1);

   logic [c_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`else
   typedef enum logic [1:0] {StIdle, StHeld} state_e;
`endif

   state_e     state_q, state_d;
   logic [1:0] held_q, held_d;
   logic       move_valid_q, move_valid_d;
   logic [1:0] move_dir_q, move_dir_d;
   logic       start_q;

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      move_valid_d = 1'b0;
      move_dir_d   = move_dir_q;
`ifdef MOVE_REPEAT_EN
      rep_cnt_d    = rep_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (i_Game_Active && (|dir_rise)) begin
               move_valid_d = 1'b1;
               move_dir_d   = win_dir;
               held_d       = win_dir;
`ifdef MOVE_REPEAT_EN
               rep_cnt_d    = '0;
               state_d      = StHeldDelay;
`else
               state_d      = StHeld;
`endif
            end
         end
`ifdef MOVE_REPEAT_EN
         StHeldDelay: begin
            if (!level[held_q]) begin
               state_d = StIdle;
            end else if (rep_cnt_q == DelayMax) begin
               move_valid_d = 1'b1;
               rep_cnt_d    = '0;
               state_d      = StRepeat;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
         StRepeat: begin
            if (!level[held_q]) begin
               state_d = StIdle;
            end else if (rep_cnt_q == PeriodMax) begin
               move_valid_d = 1'b1;
               rep_cnt_d    = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
`else
         StHeld: begin
            if (!level[held_q]) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
      // Losing game-active abandons any hold; a fresh rise is needed afterwards
      if (!i_Game_Active) begin
         state_d      = StIdle;
         move_valid_d = 1'b0;
         move_dir_d   = move_dir_q;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q      <= StIdle;
         held_q       <= 2'd0;
         move_valid_q <= 1'b0;
         move_dir_q   <= 2'd0;
         start_q      <= 1'b0;
`ifdef MOVE_REPEAT_EN
         rep_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         held_q       <= held_d;
         move_valid_q <= move_valid_d;
         move_dir_q   <= move_dir_d;
         start_q      <= rise[4];
`ifdef MOVE_REPEAT_EN
         rep_cnt_q    <= rep_cnt_d;
`endif
      end
   end

   assign o_Move_Valid  = move_valid_q & i_Game_Active;
   assign o_Move_Dir    = move_dir_q;
   assign o_Start_Pulse = start_q;
   assign o_Btn_State   = level[3:0];

endmodule

// File: tb/tb_frogger_move_input.sv
// Directed bench for frogger_move_input; pulses are matched against a queue of expected events.
module tb_frogger_move_input;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 5;
   localparam int unsigned W  = 8;

   logic       clk = 1'b0;
   logic       rst, up, down, left, right, start, active;
   logic       o_Move_Valid, o_Start_Pulse;
   logic [1:0] o_Move_Dir;
   logic [3:0] o_Btn_State;

   always #5 clk = ~clk;

   frogger_move_input #(
      .c_DEBOUNCE_LIMIT(DB),
      .c_REPEAT_DELAY  (RD),
      .c_REPEAT_PERIOD (RP),
      .c_CNT_W         (W)
   ) dut (
      .i_Clk        (clk),
      .i_Reset      (rst),
      .i_Up_Mvt     (up),
      .i_Down_Mvt   (down),
      .i_Left_Mvt   (left),
      .i_Right_Mvt  (right),
      .i_Game_Start (start),
      .i_Game_Active(active),
      .o_Move_Valid (o_Move_Valid),
      .o_Move_Dir   (o_Move_Dir),
      .o_Start_Pulse(o_Start_Pulse),
      .o_Btn_State  (o_Btn_State)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;  // 0 = move, 1 = start
      int         cyc;
      logic [1:0] dir;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  rep_offs[6] = '{7, 17, 22, 27, 32, 37};

   task automatic push(input int kind, input int c, input logic [1:0] dir);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.dir  = dir;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_ev(input int kind, input logic [1:0] dir);
      ev_t e;
      total++;
      assert (exp_q.size() != 0)
      else begin
         bad++;
         $error("FAIL unexpected_pulse: observed kind=%0d dir=%0d cyc=%0d expected none",
                kind, dir, cyc);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         assert (e.kind == kind && e.cyc == cyc && (kind == 1 || e.dir === dir))
         else begin
            bad++;
            $error("FAIL pulse: observed kind=%0d cyc=%0d dir=%0d expected kind=%0d cyc=%0d dir=%0d",
                   kind, cyc, dir, e.kind, e.cyc, e.dir);
         end
      end
   endtask

   // Caller is always in a negedge slot, where cyc is stable
   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (o_Move_Valid === 1'b1)  check_ev(0, o_Move_Dir);
      if (o_Start_Pulse === 1'b1) check_ev(1, 2'd0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; start = 1'b0;
      active = 1'b1;
      @(negedge clk);
      to_cyc(3);
      chk("reset_valid", o_Move_Valid, 0);
      chk("reset_dir", o_Move_Dir, 0);
      chk("reset_start", o_Start_Pulse, 0);
      chk("reset_btn", o_Btn_State, 0);
      rst = 1'b0;

      // 1: single up press, latency and debounced level timing
      t0 = cyc + 2; to_cyc(t0);
      up = 1'b1; push(0, t0 + 7, 2'd0);
      to_cyc(t0 + 5); chk("s1_btn_pre", o_Btn_State, 4'b0000);
      to_cyc(t0 + 6); chk("s1_btn_up", o_Btn_State, 4'b0001);
      to_cyc(t0 + 8); up = 1'b0;  // level drops before any repeat could fire
      to_cyc(t0 + 20); chk("s1_drained", exp_q.size(), 0);

      // 2: 3-cycle glitch is rejected
      t0 = cyc + 2; to_cyc(t0);
      left = 1'b1;
      to_cyc(t0 + 3); left = 1'b0;
      to_cyc(t0 + 6); chk("s2_btn_mid", o_Btn_State, 4'b0000);
      to_cyc(t0 + 12); chk("s2_btn_end", o_Btn_State, 4'b0000);
      chk("s2_drained", exp_q.size(), 0);

      // 3: simultaneous down+right, down wins; right never fires
      t0 = cyc + 2; to_cyc(t0);
      down = 1'b1; right = 1'b1; push(0, t0 + 7, 2'd1);
      to_cyc(t0 + 8); chk("s3_btn_both", o_Btn_State, 4'b1010);
      to_cyc(t0 + 10); down = 1'b0;
      to_cyc(t0 + 20); chk("s3_btn_right", o_Btn_State, 4'b1000);
      to_cyc(t0 + 40); right = 1'b0;
      to_cyc(t0 + 50); chk("s3_drained", exp_q.size(), 0);

      // 4: hold right; debounced level stays high through cycle 39
      t0 = cyc + 2; to_cyc(t0);
      right = 1'b1;
`ifdef MOVE_REPEAT_EN
      for (int i = 0; i < 6; i++) push(0, t0 + rep_offs[i], 2'd3);
`else
      push(0, t0 + rep_offs[0], 2'd3);
`endif
      to_cyc(t0 + 3); chk("s4_dir_hold", o_Move_Dir, 2'd1);
      to_cyc(t0 + 34); right = 1'b0;
      to_cyc(t0 + 39); chk("s4_btn_held", o_Btn_State, 4'b1000);
      to_cyc(t0 + 40); chk("s4_btn_rel", o_Btn_State, 4'b0000);
      to_cyc(t0 + 60); chk("s4_drained", exp_q.size(), 0);

      // 5: game inactive, start still pulses; activating while held gives no move
      t0 = cyc + 2; to_cyc(t0);
      active = 1'b0; up = 1'b1; start = 1'b1; push(1, t0 + 7, 2'd0);
      to_cyc(t0 + 8); chk("s5_start_once", o_Start_Pulse, 0);
      chk("s5_btn", o_Btn_State, 4'b0001);
      to_cyc(t0 + 12); active = 1'b1;
      to_cyc(t0 + 20); up = 1'b0; start = 1'b0;
      to_cyc(t0 + 35); chk("s5_drained", exp_q.size(), 0);

      // 6: reset during HELD_DELAY discards the hold
      t0 = cyc + 2; to_cyc(t0);
      down = 1'b1; push(0, t0 + 7, 2'd1);
      to_cyc(t0 + 10); rst = 1'b1; down = 1'b0;
      to_cyc(t0 + 11);
      chk("s6_valid", o_Move_Valid, 0);
      chk("s6_dir", o_Move_Dir, 0);
      chk("s6_start", o_Start_Pulse, 0);
      chk("s6_btn", o_Btn_State, 0);
      rst = 1'b0;
      to_cyc(t0 + 30); chk("s6_quiet", exp_q.size(), 0);
      down = 1'b1; push(0, t0 + 37, 2'd1);
      to_cyc(t0 + 38); down = 1'b0;
      to_cyc(t0 + 55); chk("s6_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
